t03_fetch_unit: RTL and testbench
=================================

# t03_fetch_unit

Instruction fetch and program-counter unit for the team_03 core. Consumes the 2-bit PC-select `control` produced by the branch-control logic and computes the next PC as sequential, PC-relative taken, or register-indirect. Owns the PC register and runs a req/ack handshake to instruction memory. Holds each fetched instruction stable for decode until execute retires it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nRst`  in  1  reset, asynchronous, active-low.
- `control`  in  2  PC select from branch control:
  - bit0 = register-indirect jump (jalr).
  - bit1 = PC-relative taken (branch or jal).
- `imm`  in  32  sign-extended immediate of the current instruction.
- `rs1_data`  in  32  rs1 operand for register-indirect targets.
- `exec_done`  in  1  current instruction retires this cycle; PC may advance.
- `freeze`  in  1  blocks the start of a new fetch.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  registered instruction for decode.
- `instr_valid`  out  1  `instr` is valid and not yet retired.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, the link value for jal/jalr.
- `misaligned`  out  1  sticky flag: a taken target was not 4-byte aligned.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- **IDLE**
  - Entered on reset.
  - Goes to FETCH the first cycle `freeze` = 0.
- **FETCH**
  - `imem_req` = 1, with `imem_addr` = `pc` held stable.
  - On the cycle `imem_ack` = 1: `instr` <= `imem_rdata` and state goes to EXEC.
  - `freeze` is ignored in FETCH; an issued request is never withdrawn.
- **EXEC**
  - `instr_valid` = 1.
  - On `exec_done` = 1 and `freeze` = 0: `pc` <= `next_pc`.
  - Then state goes to FETCH, or to HALT if `next_pc[1:0]` != 0.
  - `exec_done` while `freeze` = 1 is ignored. Execute must hold `exec_done` until it is accepted.
- **HALT**
  - `imem_req` = 0 and `instr_valid` = 0.
  - `misaligned` = 1 and `pc` is not updated.
  - Left only by reset.
- `next_pc` selection, in priority order:
  - `control[0]`: (`rs1_data` + `imm`) with bit0 forced to 0.
  - else `control[1]`: `pc` + `imm`.
  - else `pc` + 4.
- Arithmetic: all additions are 32-bit, modulo 2^32; carry is discarded, so wrap-around is legal.
- When both control bits are 1, bit0 (jalr) wins.
- The alignment check is applied to the final `next_pc`, after jalr bit0 clearing.
- `imem_ack` outside FETCH is ignored.

## Timing
- Reset values (applied asynchronously while `nRst` = 0):
  - `pc` = `RESET_PC`, state = IDLE.
  - `imem_req` = 0, `instr` = 0, `instr_valid` = 0, `misaligned` = 0.
  - `pc_plus4` = `RESET_PC` + 4.
- First `imem_req` rises one cycle after `nRst` is released (IDLE to FETCH), assuming `freeze` = 0.
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state only; no combinational path from the memory inputs.
- With zero-wait memory (`imem_ack` in the first FETCH cycle), `instr_valid` rises the next cycle.
- Throughput: minimum 2 cycles per instruction (1 FETCH + 1 EXEC).
- `instr_valid` falls the cycle after `exec_done` is accepted. `pc` and `pc_plus4` update on that same edge.
- Reset asserted mid-request: `imem_req` drops immediately (asynchronously); any ack arriving later is ignored.

## Structure
- Shared package `t03_fetch_pkg` holds:
  - the state enum (IDLE, FETCH, EXEC, HALT);
  - `PC_INC` = 4;
  - the `control` bit-position constants `CTRL_JALR` = 0 and `CTRL_TAKEN` = 1, shared with branch control.
- One sub-module, `t03_next_pc`: purely combinational target adders, priority mux and alignment check.
- Everything sequential (PC register, FSM, instruction register, sticky flag) lives in `t03_fetch_unit`.

## Test plan
- **Reset and first fetch:** release `nRst`, memory acks 2 cycles after `imem_req` rises.
  - `imem_req` rises 1 cycle after release, with `imem_addr` = 0.
  - `instr` = `imem_rdata` and `instr_valid` = 1 after the ack.
- **Sequential flow:** `control` = 00, `exec_done` pulses, pc = 0x100.
  - Next `imem_addr` = 0x104, `pc_plus4` = 0x108.
  - Steady state is 2 cycles per instruction with zero-wait memory.
- **Branch and wrap:** `control` = 10.
  - pc = 0x100, `imm` = 0xFFFF_FFF8: next pc = 0xF8.
  - pc = 0xFFFF_FFFC, `imm` = 8: next pc = 0x4 (wraps).
- **jalr priority and bit0 clear:** `control` = 11, `rs1_data` = 0x2001, `imm` = 3, pc = 0x40.
  - Next pc = 0x2004, not 0x43.
- **Misaligned target:** `control` = 10, pc = 0x10, `imm` = 6.
  - State goes to HALT, `misaligned` = 1, `imem_req` stays 0, `pc` stays 0x10 until reset.
- **Freeze and reset mid-request:**
  - `freeze` = 1 with `exec_done` held in EXEC: pc holds; it advances the cycle after `freeze` drops.
  - `nRst` pulsed while `imem_req` = 1 and no ack: `imem_req` = 0 immediately and pc = `RESET_PC`.

Source files
------------

// File: rtl/t03_fetch_pkg.sv
// Shared types and constants for the team_03 instruction fetch unit.
// The control bit positions are also consumed by branch control.
package t03_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  localparam int CTRL_JALR  = 0;
  localparam int CTRL_TAKEN = 1;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/t03_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface t03_fetch_unit_if;

  // Handshake: the master raises imem_req with imem_addr stable and keeps both
  // unchanged until the slave answers with imem_ack=1 (imem_rdata valid in that
  // same cycle). A raised request is never withdrawn before its ack.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/t03_next_pc.sv
// Combinational next-PC selection: jalr / PC-relative / sequential targets,
// priority mux and alignment check of the final target.
module t03_next_pc
  import t03_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic [1:0]  control,
  output logic [31:0] next_pc,
  output logic        target_misaligned
);

  logic [31:0] seq_target;
  logic [31:0] rel_target;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_target;

  // All sums are modulo 2^32; the carry-out is dropped on purpose.
  assign seq_target  = pc + PC_INC;
  assign rel_target  = pc + imm;
  assign jalr_sum    = rs1_data + imm;
  assign jalr_target = {jalr_sum[31:1], 1'b0};

  always_comb begin
    next_pc = seq_target;
    if (control[CTRL_JALR]) begin
      next_pc = jalr_target;
    end else if (control[CTRL_TAKEN]) begin
      next_pc = rel_target;
    end
  end

  // Checked after the jalr bit0 clear, so only bit1 can trip a jalr target.
  assign target_misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/t03_fetch_unit.sv
// Instruction fetch / PC unit: owns the PC, runs the imem req/ack handshake and
// holds the fetched instruction for decode until execute retires it.
module t03_fetch_unit
  import t03_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [1:0]        control,
  input  logic [31:0]       imm,
  input  logic [31:0]       rs1_data,
  input  logic              exec_done,
  input  logic              freeze,
  t03_fetch_unit_if.master  imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              misaligned,
  output fetch_state_e      dbg_state
);

  fetch_state_e state;
  fetch_state_e state_next;

  logic [31:0] next_pc;
  logic        target_misaligned;
  logic        pc_load;
  logic        instr_load;
  logic        halt_set;

  t03_next_pc u_next_pc (
    .pc                (pc),
    .imm               (imm),
    .rs1_data          (rs1_data),
    .control           (control),
    .next_pc           (next_pc),
    .target_misaligned (target_misaligned)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    halt_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!freeze) begin
          state_next = FETCH;
        end
      end
      // freeze only gates the start of a fetch; an outstanding request stays up.
      FETCH: begin
        if (imem.imem_ack) begin
          instr_load = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (exec_done && !freeze) begin
          if (target_misaligned) begin
            halt_set   = 1'b1;
            state_next = HALT;
          end else begin
            pc_load    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A misaligned target is never loaded: pc keeps the faulting instruction.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      instr <= '0;
    end else if (instr_load) begin
      instr <= imem.imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      misaligned <= 1'b0;
    end else if (halt_set) begin
      misaligned <= 1'b1;
    end
  end

  // Bus outputs come from registered state only, never from imem inputs.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);
  assign pc_plus4       = pc + PC_INC;
  assign dbg_state      = state;

endmodule

// File: tb/tb_t03_fetch_unit.sv
// Directed self-checking bench for t03_fetch_unit.
module tb_t03_fetch_unit;
  import t03_fetch_pkg::*;

  logic        clk;
  logic        nRst;
  logic [1:0]  control;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        exec_done;
  logic        freeze;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c0;

  t03_fetch_unit_if imem_bus ();

  t03_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .control     (control),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .exec_done   (exec_done),
    .freeze      (freeze),
    .imem        (imem_bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misaligned  (misaligned),
    .dbg_state   (dbg_state)
  );

  // Clock / reset-independent time base
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: retire the instruction in EXEC with the given PC select.
  task automatic retire(input logic [1:0] c, input logic [31:0] i, input logic [31:0] r);
    control   = c;
    imm       = i;
    rs1_data  = r;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    control   = 2'b00;
    imm       = '0;
    rs1_data  = '0;
  endtask

  // Driver: zero-wait memory answer in the current FETCH cycle.
  task automatic fetch(input logic [31:0] w);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = w;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
  endtask

  initial begin
    nRst = 1'b0; control = '0; imm = '0; rs1_data = '0;
    exec_done = 1'b0; freeze = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});

    // Freeze holds IDLE, then first request one cycle after it drops
    freeze = 1'b1;
    nRst   = 1'b1;
    @(negedge clk);
    check("idle_freeze_state", {30'b0, dbg_state}, {30'b0, IDLE});
    check("idle_freeze_req", {31'b0, imem_bus.imem_req}, 32'd0);
    freeze = 1'b0;
    @(negedge clk);
    check("first_req", {31'b0, imem_bus.imem_req}, 32'd1);
    check("first_addr", imem_bus.imem_addr, 32'h0);

    // Memory acks two cycles later; request must stay up meanwhile
    @(negedge clk);
    check("wait_req", {31'b0, imem_bus.imem_req}, 32'd1);
    check("wait_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    fetch(32'h0000_0013);
    check("first_instr", instr, 32'h0000_0013);
    check("first_valid", {31'b0, instr_valid}, 32'd1);
    check("first_req_low", {31'b0, imem_bus.imem_req}, 32'd0);

    // Get to pc=0x100, then sequential flow
    retire(2'b01, 32'h0, 32'h100);
    check("jmp100_pc", pc, 32'h100);
    check("jmp100_valid", {31'b0, instr_valid}, 32'd0);
    fetch(32'hAAAA_0001);
    c0 = cyc;
    retire(2'b00, 32'h1234, 32'h5678);
    check("seq_addr", imem_bus.imem_addr, 32'h104);
    check("seq_pc_plus4", pc_plus4, 32'h108);
    fetch(32'hAAAA_0002);
    check("seq_instr", instr, 32'hAAAA_0002);
    retire(2'b00, 32'h0, 32'h0);
    fetch(32'hAAAA_0003);
    check("seq_pc2", pc, 32'h108);
    check("seq_throughput", cyc - c0, 32'd4);
    check("seq_valid", {31'b0, instr_valid}, 32'd1);

    // PC-relative branch backwards, then wrap-around
    retire(2'b01, 32'h0, 32'h100);
    fetch(32'hBBBB_0001);
    retire(2'b10, 32'hFFFF_FFF8, 32'h0);
    check("br_back_pc", pc, 32'h0000_00F8);
    fetch(32'hBBBB_0002);
    retire(2'b01, 32'h0, 32'hFFFF_FFFC);
    check("br_top_pc", pc, 32'hFFFF_FFFC);
    check("br_top_pc_plus4", pc_plus4, 32'h0);
    fetch(32'hBBBB_0003);
    retire(2'b10, 32'h8, 32'h0);
    check("br_wrap_pc", pc, 32'h4);
    fetch(32'hBBBB_0004);

    // jalr wins over taken, bit0 cleared
    retire(2'b01, 32'h0, 32'h40);
    fetch(32'hCCCC_0001);
    check("jalr_pre_plus4", pc_plus4, 32'h44);
    retire(2'b11, 32'h3, 32'h2001);
    check("jalr_pc", pc, 32'h2004);
    fetch(32'hCCCC_0002);

    // freeze with exec_done held; stray ack in EXEC ignored
    freeze = 1'b1;
    control = 2'b00;
    exec_done = 1'b1;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("frz_pc", pc, 32'h2004);
    check("frz_state", {30'b0, dbg_state}, {30'b0, EXEC});
    check("frz_instr", instr, 32'hCCCC_0002);
    imem_bus.imem_ack = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    exec_done = 1'b0;
    check("unfrz_pc", pc, 32'h2008);
    check("unfrz_state", {30'b0, dbg_state}, {30'b0, FETCH});
    fetch(32'hCCCC_0003);

    // Misaligned target halts
    retire(2'b01, 32'h0, 32'h10);
    fetch(32'hDDDD_0001);
    retire(2'b10, 32'h6, 32'h0);
    check("mis_state", {30'b0, dbg_state}, {30'b0, HALT});
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    check("mis_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check("mis_valid", {31'b0, instr_valid}, 32'd0);
    check("mis_pc", pc, 32'h10);
    control = 2'b01; rs1_data = 32'h200; exec_done = 1'b1;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1111_2222;
    repeat (3) @(negedge clk);
    check("halt_pc", pc, 32'h10);
    check("halt_state", {30'b0, dbg_state}, {30'b0, HALT});
    check("halt_instr", instr, 32'hDDDD_0001);
    check("halt_req", {31'b0, imem_bus.imem_req}, 32'd0);
    control = 2'b00; rs1_data = '0; exec_done = 1'b0;
    imem_bus.imem_ack = 1'b0;

    // Reset clears HALT; then reset asserted mid-request
    nRst = 1'b0;
    @(negedge clk);
    check("rst2_flag", {31'b0, misaligned}, 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    fetch(32'hEEEE_0001);
    retire(2'b01, 32'h0, 32'h80);
    check("midreq_req", {31'b0, imem_bus.imem_req}, 32'd1);
    check("midreq_addr", imem_bus.imem_addr, 32'h80);
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("async_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check("async_pc", pc, 32'h0);
    check("async_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(negedge clk);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h5555_5555;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    nRst = 1'b1;
    @(negedge clk);
    check("post_rst_req", {31'b0, imem_bus.imem_req}, 32'd1);
    check("post_rst_addr", imem_bus.imem_addr, 32'h0);
    check("post_rst_instr", instr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
